instr_mem_responder: RTL and testbench



---
 rtl/instr_mem_responder_if.sv | 21 ++
 rtl/instr_mem_responder.sv | 120 ++++++++++++
 tb/tb_instr_mem_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_responder_if.sv
// Fetch and loader bus between the CPU/boot loader (master) and the
// instruction memory responder (slave).
interface instr_mem_responder_if;
  logic [31:0] pc;
  logic        read;
  logic [31:0] instruction;
  logic        busywait;
  logic        load_en;
  logic [31:0] load_addr;
  logic [7:0]  load_data;

  modport master (
    output pc, read, load_en, load_addr, load_data,
    input  instruction, busywait
  );

  modport slave (
    input  pc, read, load_en, load_addr, load_data,
    output instruction, busywait
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-side responder: byte-addressed store, fixed-latency miss path
// with BUSYWAIT, and a one-word fetch buffer serving repeated fetches.
module instr_mem_responder #(
  parameter int DEPTH_BYTES  = 1024,
  parameter int READ_LATENCY = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  instr_mem_responder_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int IW    = (AW > 2) ? AW - 2 : 1;
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int CW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t        r_state;
  logic [IW-1:0] r_tag;
  logic          r_valid;
  logic [31:0]   r_word;
  logic [31:0]   r_instr;
  logic [IW-1:0] r_req_idx;
  logic [CW-1:0] r_cnt;

  logic [IW-1:0] w_pc_idx;
  logic [IW-1:0] w_ld_idx;
  logic [1:0]    w_ld_lane;
  logic [31:0]   w_rd_word;
  logic          w_hit;
  logic          w_ld_tag;
  logic          w_ld_req;
  logic          w_abort;
  logic          w_busy;
  logic          w_unused_bits;

  if (AW > 2) begin : g_idx
    assign w_pc_idx = bus.pc[AW-1:2];
    assign w_ld_idx = bus.load_addr[AW-1:2];
  end else begin : g_idx_single
    assign w_pc_idx = '0;
    assign w_ld_idx = '0;
  end

  assign w_ld_lane     = bus.load_addr[1:0];
  assign w_unused_bits = ^{bus.pc, bus.load_addr};

  // One byte lane per array so a whole little-endian word is read at once.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [WORDS];

    always_ff @(posedge i_clk) begin
      if (bus.load_en && (w_ld_lane == 2'(gi)))
        r_mem[w_ld_idx] <= bus.load_data;
    end

    assign w_rd_word[8*gi +: 8] = r_mem[r_req_idx];
  end

  assign w_hit    = r_valid && (r_tag == w_pc_idx);
  assign w_ld_tag = bus.load_en && (w_ld_idx == r_tag);
  assign w_ld_req = bus.load_en && (w_ld_idx == r_req_idx);
  assign w_abort  = !bus.read || (w_pc_idx != r_req_idx);

  assign w_busy = !i_rst &&
                  ((r_state == S_FETCH) ||
                   (r_state == S_IDLE && bus.read && !w_hit));

  assign bus.busywait    = w_busy;
  assign bus.instruction = r_instr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_tag     <= '0;
      r_valid   <= 1'b0;
      r_word    <= '0;
      r_instr   <= '0;
      r_req_idx <= '0;
      r_cnt     <= '0;
    end else begin
      // A write into the buffered word invalidates it; completion below may
      // set it again only for a different (freshly read) word.
      if (w_ld_tag)
        r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.read) begin
            if (w_hit && !w_ld_tag) begin
              r_instr <= r_word;
            end else begin
              r_req_idx <= w_pc_idx;
              r_cnt     <= CNT_INIT;
              r_state   <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (w_abort) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_ld_req) begin
            r_cnt <= CNT_INIT;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_word  <= w_rd_word;
            r_instr <= w_rd_word;
            r_tag   <= r_req_idx;
            r_valid <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: miss latency, buffer hits, wrap,
// loader coherency during FETCH and IDLE, abort and asynchronous reset.
module tb_instr_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  instr_mem_responder_if bus();

  instr_mem_responder #(.DEPTH_BYTES(1024), .READ_LATENCY(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [31:0] addr, input logic [7:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    tick();
    bus.load_en = 1'b0;
  endtask

  // Issue a fetch, count BUSYWAIT-high cycles; optionally inject one loader
  // write during busy cycle number inj_at (0 = request cycle).
  task automatic do_fetch(input logic [31:0] pc, input int inj_at,
                          input logic [31:0] inj_addr, input logic [7:0] inj_data,
                          output int stall);
    bus.pc   = pc;
    bus.read = 1'b1;
    stall    = 0;
    #1;
    while (bus.busywait && stall < 40) begin
      if (stall == inj_at) begin
        bus.load_en   = 1'b1;
        bus.load_addr = inj_addr;
        bus.load_data = inj_data;
      end
      stall++;
      tick();
      bus.load_en = 1'b0;
    end
    tick();
    bus.read = 1'b0;
    $display("fetch pc=%h stall=%0d instr=%h", pc, stall, bus.instruction);
  endtask

  int stall;

  initial begin
    bus.pc        = 32'h0;
    bus.read      = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = 32'h0;
    bus.load_data = 8'h0;

    #2;
    chk("rst_instr", bus.instruction, 32'h0);
    chk("rst_busy", {31'b0, bus.busywait}, 32'd0);
    bus.read = 1'b1;
    #1;
    chk("rst_busy_read", {31'b0, bus.busywait}, 32'd0);
    bus.read = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Scenario 1: first miss
    for (int i = 0; i < 8; i++) load_byte(32'(i), 8'(i + 1));
    do_fetch(32'h0, -1, 32'h0, 8'h0, stall);
    chk("s1_stall", 32'(stall), 32'd5);
    chk("s1_instr", bus.instruction, 32'h04030201);

    // Scenario 2: hit, then next word
    do_fetch(32'h0, -1, 32'h0, 8'h0, stall);
    chk("s2_hit_stall", 32'(stall), 32'd0);
    chk("s2_hit_instr", bus.instruction, 32'h04030201);
    do_fetch(32'h4, -1, 32'h0, 8'h0, stall);
    chk("s2_stall", 32'(stall), 32'd5);
    chk("s2_instr", bus.instruction, 32'h08070605);

    // Scenario 3: wrap of CPU reset PC onto the last word
    load_byte(32'd1020, 8'hAA);
    load_byte(32'd1021, 8'hBB);
    load_byte(32'd1022, 8'hCC);
    load_byte(32'd1023, 8'hDD);
    do_fetch(32'hFFFF_FFFC, -1, 32'h0, 8'h0, stall);
    chk("s3_stall", 32'(stall), 32'd5);
    chk("s3_instr", bus.instruction, 32'hDDCCBBAA);

    // Scenario 4: write into the in-flight word at the 2nd FETCH cycle
    load_byte(32'd8,  8'h11);
    load_byte(32'd9,  8'h22);
    load_byte(32'd10, 8'h33);
    load_byte(32'd11, 8'h44);
    do_fetch(32'h8, 2, 32'd9, 8'h5A, stall);
    chk("s4_stall", 32'(stall), 32'd7);
    chk("s4_instr", bus.instruction, 32'h44335A11);

    // Abort: move PC back to the buffered word mid-FETCH
    do_fetch(32'h0, -1, 32'h0, 8'h0, stall);
    chk("ab_pre_stall", 32'(stall), 32'd5);
    bus.pc   = 32'h4;
    bus.read = 1'b1;
    tick();
    tick();
    bus.pc = 32'h0;
    #1;
    chk("ab_busy_fetch", {31'b0, bus.busywait}, 32'd1);
    tick();
    chk("ab_busy_idle", {31'b0, bus.busywait}, 32'd0);
    chk("ab_instr", bus.instruction, 32'h04030201);
    bus.read = 1'b0;
    tick();
    do_fetch(32'h0, -1, 32'h0, 8'h0, stall);
    chk("ab_hit_stall", 32'(stall), 32'd0);

    // Scenario 5: reset in the middle of a FETCH
    bus.pc   = 32'hC;
    bus.read = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("s5_busy", {31'b0, bus.busywait}, 32'd0);
    chk("s5_instr", bus.instruction, 32'h0);
    tick();
    chk("s5_busy_hold", {31'b0, bus.busywait}, 32'd0);
    rst = 1'b0;
    bus.read = 1'b0;
    tick();
    do_fetch(32'h0, -1, 32'h0, 8'h0, stall);
    chk("s5_refetch_stall", 32'(stall), 32'd5);
    chk("s5_refetch_instr", bus.instruction, 32'h04030201);

    // Scenario 6: loader write invalidates the buffered word
    load_byte(32'd2, 8'hFF);
    do_fetch(32'h0, -1, 32'h0, 8'h0, stall);
    chk("s6_stall", 32'(stall), 32'd5);
    chk("s6_instr", bus.instruction, 32'h04FF0201);

    // Write and hit to the same word on one IDLE edge -> treated as a miss
    bus.pc        = 32'h0;
    bus.read      = 1'b1;
    bus.load_en   = 1'b1;
    bus.load_addr = 32'd3;
    bus.load_data = 8'h77;
    #1;
    chk("wh_busy_req", {31'b0, bus.busywait}, 32'd0);
    tick();
    bus.load_en = 1'b0;
    chk("wh_instr_stale", bus.instruction, 32'h04FF0201);
    stall = 0;
    while (bus.busywait && stall < 40) begin
      stall++;
      tick();
    end
    chk("wh_stall", 32'(stall), 32'd4);
    chk("wh_instr", bus.instruction, 32'h77FF0201);
    $display("fetch pc=%h stall=%0d instr=%h", 32'h0, stall, bus.instruction);
    tick();
    bus.read = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
